spi_sclk_engine: RTL and testbench

Parametrised SPI serial-clock engine: next generation of the SPI clock generator, placed between the SPI register/control logic and the shift register. Generates `sclk_out` from `wb_clk_in` with a programmable divider, supports all four CPOL/CPHA modes and transfers of 1..2^LEN_W bits. Emits pre-edge strobes that tell the shift register when to sample and when to shift, and reports transfer progress and completion.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_half_timer.sv | 34 +++
 rtl/spi_sclk_engine.sv | 141 ++++++++++++++
 tb/tb_spi_sclk_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI serial-clock engine.
package spi_pkg;

    localparam int unsigned DefDivW = 16;
    localparam int unsigned DefLenW = 7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StRun   = 2'd2,
        StHold  = 2'd3
    } spi_state_e;

    // {cpol, cpha}
    typedef enum logic [1:0] {
        Mode0 = 2'b00,
        Mode1 = 2'b01,
        Mode2 = 2'b10,
        Mode3 = 2'b11
    } spi_mode_e;

endpackage

// File: rtl/spi_half_timer.sv
// Loadable half-period counter: counts 0..limit while enabled, flags the wrap cycle.
module spi_half_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [Width-1:0] limit,
    output logic             wrap
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign wrap = en && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: divider, CPOL/CPHA strobes, transfer progress.
// Optional slave-select with setup/hold phases when SPI_SCLK_CS_EN is defined.
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = DefDivW,
    parameter int unsigned LEN_W = DefLenW
) (
    input  logic             wb_clk_in,
    input  logic             wb_rst,
    input  logic             go,
    input  logic [DIV_W-1:0] divider,
    input  logic [LEN_W-1:0] len,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk_out,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             sample,
    output logic             shift,
    output logic             last,
    output logic             tip,
    output logic             done
`ifdef SPI_SCLK_CS_EN
    ,
    output logic             ss_n
`endif
);

`ifdef SPI_SCLK_CS_EN
    localparam bit CsEn = 1'b1;
`else
    localparam bit CsEn = 1'b0;
`endif

    spi_state_e       state_q, state_d;
    spi_mode_e        mode_q;
    logic [DIV_W-1:0] div_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   ec_q, ec_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;
    logic             load;
    logic             hc_wrap;
    logic             strobe;
    logic             leading;
    logic [LEN_W:0]   last_edge;

    spi_half_timer #(
        .Width (DIV_W)
    ) u_half_timer (
        .clk   (wb_clk_in),
        .rst   (wb_rst),
        .en    (state_q != StIdle),
        .clr   (state_q == StIdle),
        .limit (div_q),
        .wrap  (hc_wrap)
    );

    // 2N-1 in LEN_W+1 bits; len=0 wraps to all ones, i.e. 2^(LEN_W+1)-1.
    assign last_edge = {len_q, 1'b0} - {{LEN_W{1'b0}}, 1'b1};

    assign strobe   = (state_q == StRun) && hc_wrap;
    assign leading  = ~ec_q[0];
    assign pos_edge = strobe && !sclk_q;
    assign neg_edge = strobe && sclk_q;
    assign sample   = strobe && (mode_q[0] ? !leading : leading);
    assign shift    = strobe && (mode_q[0] ? leading : !leading);
    // Edges 2N-1 and 2N share ec_q[LEN_W:1]; the cpha-selected sample picks the right one.
    assign last     = sample && ({ec_q[LEN_W:1], 1'b1} == last_edge);
    assign tip      = (state_q != StIdle);
    assign done     = done_q;
    assign sclk_out = sclk_q;
`ifdef SPI_SCLK_CS_EN
    assign ss_n     = (state_q == StIdle);
`endif

    always_comb begin
        state_d = state_q;
        ec_d    = ec_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                sclk_d = cpol;
                ec_d   = '0;
                if (go) begin
                    load    = 1'b1;
                    state_d = CsEn ? StSetup : StRun;
                end
            end
            StSetup: begin
                if (hc_wrap) state_d = StRun;
            end
            StRun: begin
                if (hc_wrap) begin
                    if (ec_q == last_edge) begin
                        sclk_d  = mode_q[1];
                        ec_d    = '0;
                        state_d = CsEn ? StHold : StIdle;
                        done_d  = !CsEn;
                    end else begin
                        sclk_d = ~sclk_q;
                        ec_d   = ec_q + {{LEN_W{1'b0}}, 1'b1};
                    end
                end
            end
            StHold: begin
                if (hc_wrap) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            ec_q    <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= Mode0;
            div_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ec_q    <= ec_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
            if (load) begin
                mode_q <= spi_mode_e'({cpol, cpha});
                div_q  <= divider;
                len_q  <= len;
            end
        end
    end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine; CS timing is exercised when SPI_SCLK_CS_EN is defined.
module tb_spi_sclk_engine;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned LEN_W = 7;

    logic             wb_clk_in = 1'b0;
    logic             wb_rst    = 1'b1;
    logic             go        = 1'b0;
    logic [DIV_W-1:0] divider   = '0;
    logic [LEN_W-1:0] len       = '0;
    logic             cpol      = 1'b0;
    logic             cpha      = 1'b0;
    logic             sclk_out, pos_edge, neg_edge, sample, shift, last, tip, done;
`ifdef SPI_SCLK_CS_EN
    logic             ss_n;
`endif
    logic [5:0]       strb;
    logic [5:0]       e;
    int               vectors     = 0;
    int               miscompares = 0;
    int               cyc, n_edge, n_sample, n_last, n_done;

    always #5 wb_clk_in = ~wb_clk_in;

    spi_sclk_engine #(
        .DIV_W (DIV_W),
        .LEN_W (LEN_W)
    ) dut (
        .wb_clk_in (wb_clk_in),
        .wb_rst    (wb_rst),
        .go        (go),
        .divider   (divider),
        .len       (len),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk_out  (sclk_out),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .sample    (sample),
        .shift     (shift),
        .last      (last),
        .tip       (tip),
        .done      (done)
`ifdef SPI_SCLK_CS_EN
        ,
        .ss_n      (ss_n)
`endif
    );

    // {pos_edge, neg_edge, sample, shift, last, tip}
    assign strb = {pos_edge, neg_edge, sample, shift, last, tip};

    task automatic tick();
        @(posedge wb_clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle 1 of the new transfer.
    task automatic start(input int d, input int l, input logic p, input logic h);
        divider = DIV_W'(d);
        len     = LEN_W'(l);
        cpol    = p;
        cpha    = h;
        go      = 1'b1;
        tick();
        go      = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_sclk", int'(sclk_out), 0);
        chk("rst_strb", int'(strb), 0);
        chk("rst_done", int'(done), 0);
        ticks(2);
        wb_rst = 1'b0;
        ticks(2);

`ifdef SPI_SCLK_CS_EN
        start(1, 2, 1'b0, 1'b0);
        chk("cs_c1_ssn", int'(ss_n), 0);
        chk("cs_c1_strb", int'(strb), 6'b000001);
        tick();
        chk("cs_c2_strb", int'(strb), 6'b000001);
        ticks(2);
        chk("cs_c4_strb", int'(strb), 6'b101001);
        ticks(8);
        chk("cs_c12_ssn", int'(ss_n), 0);
        chk("cs_c12_strb", int'(strb), 6'b000001);
        tick();
        chk("cs_c13_ssn", int'(ss_n), 1);
        chk("cs_c13_done", int'(done), 1);
        chk("cs_c13_tip", int'(tip), 0);
        chk("cs_c13_sclk", int'(sclk_out), 0);
`else
        // Mode 0, divider 0, len 8
        start(0, 8, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k % 2 == 1) e = {1'b1, 1'b0, 1'b1, 1'b0, (k == 15), 1'b1};
            else            e = 6'b010101;
            chk($sformatf("m0_c%0d", k), int'(strb), int'(e));
            tick();
        end
        chk("m0_done", int'(done), 1);
        chk("m0_idle_strb", int'(strb), 0);
        chk("m0_sclk", int'(sclk_out), 0);
        tick();
        chk("m0_done_pulse", int'(done), 0);

        // Mode 3, divider 3, len 1
        start(3, 1, 1'b1, 1'b1);
        chk("m3_c1_sclk", int'(sclk_out), 1);
        chk("m3_c1_strb", int'(strb), 6'b000001);
        ticks(2);
        chk("m3_c3_strb", int'(strb), 6'b000001);
        tick();
        chk("m3_c4_strb", int'(strb), 6'b010101);
        tick();
        chk("m3_c5_sclk", int'(sclk_out), 0);
        ticks(3);
        chk("m3_c8_strb", int'(strb), 6'b101011);
        tick();
        chk("m3_c9_done", int'(done), 1);
        chk("m3_c9_sclk", int'(sclk_out), 1);
        chk("m3_c9_strb", int'(strb), 0);

        // len 0: 2^LEN_W bits
        start(0, 0, 1'b0, 1'b0);
        cyc = 1; n_edge = 0; n_sample = 0; n_last = 0;
        while (!done && cyc < 400) begin
            n_edge   += int'(pos_edge) + int'(neg_edge);
            n_sample += int'(sample);
            n_last   += int'(last);
            tick();
            cyc++;
        end
        chk("len0_done_cycle", cyc, 257);
        chk("len0_edges", n_edge, 256);
        chk("len0_samples", n_sample, 128);
        chk("len0_lasts", n_last, 1);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_done += int'(done);
        end
        chk("len0_extra_done", n_done, 0);

        // Mode 1, divider 1, len 2; go ignored mid-transfer, accepted in done cycle
        start(1, 2, 1'b0, 1'b1);
        chk("b2b_c1_strb", int'(strb), 6'b000001);
        tick();
        chk("b2b_c2_strb", int'(strb), 6'b100101);
        tick();
        go = 1'b1; divider = '0; len = LEN_W'(1); cpol = 1'b1; cpha = 1'b0;
        chk("b2b_c3_strb", int'(strb), 6'b000001);
        tick();
        go = 1'b0;
        chk("b2b_c4_strb", int'(strb), 6'b011001);
        tick();
        chk("b2b_c5_strb", int'(strb), 6'b000001);
        ticks(3);
        chk("b2b_c8_strb", int'(strb), 6'b011011);
        tick();
        chk("b2b_c9_done", int'(done), 1);
        chk("b2b_c9_tip", int'(tip), 0);
        go = 1'b1; divider = '0; len = LEN_W'(1); cpol = 1'b0; cpha = 1'b0;
        tick();
        go = 1'b0;
        chk("b2b_c10_strb", int'(strb), 6'b101011);
        tick();
        chk("b2b_c11_strb", int'(strb), 6'b010101);
        tick();
        chk("b2b_c12_done", int'(done), 1);
        tick();
        chk("b2b_c13_done", int'(done), 0);

        // Mode 2, divider 1, len 4; reset at edge 5
        start(1, 4, 1'b1, 1'b0);
        chk("rst2_c1_sclk", int'(sclk_out), 1);
        tick();
        chk("rst2_c2_strb", int'(strb), 6'b011001);
        ticks(8);
        chk("rst2_c10_strb", int'(strb), 6'b011001);
        wb_rst = 1'b1;
        #1;
        chk("rst2_async_sclk", int'(sclk_out), 0);
        chk("rst2_async_strb", int'(strb), 0);
        chk("rst2_async_done", int'(done), 0);
        tick();
        chk("rst2_held_strb", int'(strb), 0);
        wb_rst = 1'b0;
        tick();
        chk("rst2_rel_sclk", int'(sclk_out), 1);
        chk("rst2_rel_tip", int'(tip), 0);
        n_done = int'(done);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_done += int'(done);
        end
        chk("rst2_no_done", n_done, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
